// File: rtl/stage_muldiv.sv
// rtl/stage_muldiv.sv - multi-cycle multiply/divide unit with HI/LO registers and stall request
//
// Purpose: owns HI/LO and runs MULT/MULTU/DIV/DIVU over a fixed busy window.
// It also executes MTHI/MTLO and serves MFHI/MFLO reads through rd_data.
// The result is computed at accept, held, and written to HI/LO on the last busy edge.
//
// Optional feature: define MD_MADD_EN to accept MADD/MADDU/MSUB/MSUBU (opcodes 7-10).
//
// Ports:
//   clk       - clock, all state on rising edge
//   reset_n   - synchronous active-low reset
//   op_valid  - execute-stage md operation present
//   md_op     - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7-10 MADD family
//   rs_val    - dividend / multiplicand / MT source
//   rt_val    - divisor / multiplier
//   rd_sel    - 1 selects HI, 0 selects LO onto rd_data
//   d_md_use  - decode-stage instruction needs the unit
//   busy      - multi-cycle operation in progress
//   stall_req - stall decode/fetch
//   hi, lo    - HI/LO registers
//   rd_data   - rd_sel ? hi : lo
module stage_muldiv #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_sel,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic          wr_pend_q, wr_pend_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        is_mul, is_div, accept, idle_op;
  logic [63:0] prod_s, prod_u;
  logic [31:0] divisor, ua, ub, uq, ur;
  logic        neg_a, neg_b;

  assign busy    = (cnt_q != '0);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = rd_sel ? hi_q : lo_q;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    case (md_op)
      4'd1, 4'd2: is_mul = 1'b1;
      4'd3, 4'd4: is_div = 1'b1;
`ifdef MD_MADD_EN
      4'd7, 4'd8, 4'd9, 4'd10: is_mul = 1'b1;
`endif
      default: ;
    endcase
  end

  assign idle_op   = op_valid & ~busy;
  assign accept    = idle_op & (is_mul | is_div);
  assign stall_req = d_md_use & (busy | accept);

  // Products on sign/zero-extended operands; the low 64 bits are exact either way.
  assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  // A zero divisor is replaced by 1 only to keep the datapath defined; its result is discarded.
  always_comb begin
    divisor = (rt_val == 32'd0) ? 32'd1 : rt_val;
    neg_a   = (md_op == 4'd3) & rs_val[31];
    neg_b   = (md_op == 4'd3) & divisor[31];
    ua      = neg_a ? -rs_val : rs_val;
    ub      = neg_b ? -divisor : divisor;
    uq      = ua / ub;
    ur      = ua % ub;
  end

  always_comb begin
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;
    wr_pend_d = wr_pend_q;
    cnt_d     = busy ? cnt_q - 1'b1 : cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (accept) begin
      cnt_d     = is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
      wr_pend_d = ~(is_div & (rt_val == 32'd0));
      case (md_op)
        4'd1: {res_hi_d, res_lo_d} = prod_s;
        4'd2: {res_hi_d, res_lo_d} = prod_u;
        4'd3, 4'd4: begin
          res_lo_d = (neg_a ^ neg_b) ? -uq : uq;
          res_hi_d = neg_a ? -ur : ur;
        end
`ifdef MD_MADD_EN
        // Accumulate against HI/LO as they stand at accept.
        4'd7:  {res_hi_d, res_lo_d} = {hi_q, lo_q} + prod_s;
        4'd8:  {res_hi_d, res_lo_d} = {hi_q, lo_q} + prod_u;
        4'd9:  {res_hi_d, res_lo_d} = {hi_q, lo_q} - prod_s;
        4'd10: {res_hi_d, res_lo_d} = {hi_q, lo_q} - prod_u;
`endif
        default: ;
      endcase
    end

    // cnt_q == 1 implies busy, so MTHI/MTLO can never collide with write-back.
    if ((cnt_q == CW'(1)) && wr_pend_q) begin
      hi_d = res_hi_q;
      lo_d = res_lo_q;
    end else if (idle_op && (md_op == 4'd5)) begin
      hi_d = rs_val;
    end else if (idle_op && (md_op == 4'd6)) begin
      lo_d = rs_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_q      <= '0;
      lo_q      <= '0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
      wr_pend_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
      wr_pend_q <= wr_pend_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_stage_muldiv.sv
// tb/tb_stage_muldiv.sv - directed self-checking bench for stage_muldiv
module tb_stage_muldiv;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_sel;
  logic        d_md_use;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  int checks = 0;
  int failures = 0;

  stage_muldiv #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .rd_sel(rd_sel), .d_md_use(d_md_use),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    op_valid = 1'b0;
    md_op    = 4'd0;
    rs_val   = 32'd0;
    rt_val   = 32'd0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    op_valid = 1'b1;
    md_op    = op;
    rs_val   = v;
    tick();
    idle_in();
  endtask

  // Issue one op, then check busy/stall for n cycles and HI/LO afterwards.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic dmu,
                        input logic [31:0] ehi, input logic [31:0] elo);
    op_valid = 1'b1;
    md_op    = op;
    rs_val   = a;
    rt_val   = b;
    d_md_use = dmu;
    #1;
    check({tag, " stall_at_accept"}, {31'd0, stall_req}, {31'd0, dmu && (n > 0)});
    tick();
    idle_in();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s busy[%0d]", tag, i), {31'd0, busy}, 32'd1);
      check($sformatf("%s stall[%0d]", tag, i), {31'd0, stall_req}, {31'd0, dmu});
      tick();
    end
    check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, " stall_after"}, {31'd0, stall_req}, 32'd0);
    check({tag, " hi"}, hi, ehi);
    check({tag, " lo"}, lo, elo);
    d_md_use = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    rd_sel   = 1'b0;
    d_md_use = 1'b1;
    idle_in();
    tick();
    tick();
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst stall", {31'd0, stall_req}, 32'd0);
    reset_n  = 1'b1;
    d_md_use = 1'b0;
    tick();

    run_op("mult",  4'd1, 32'hFFFFFFFE, 32'd3, 5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 5, 1'b0, 32'h00000002, 32'hFFFFFFFA);
    run_op("div",   4'd3, 32'hFFFFFFF9, 32'd2, 10, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",  4'd4, 32'd7, 32'd2, 10, 1'b1, 32'd1, 32'd3);
    run_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, 32'd0, 32'h80000000);

    // MTLO while idle: single cycle, no busy, readable through rd_data.
    d_md_use = 1'b1;
    op_valid = 1'b1;
    md_op    = 4'd6;
    rs_val   = 32'h1234;
    #1;
    check("mtlo stall", {31'd0, stall_req}, 32'd0);
    tick();
    idle_in();
    d_md_use = 1'b0;
    check("mtlo lo", lo, 32'h1234);
    check("mtlo busy", {31'd0, busy}, 32'd0);
    rd_sel = 1'b0;
    #1;
    check("mflo rd_data", rd_data, 32'h1234);
    rd_sel = 1'b1;
    #1;
    check("mfhi rd_data", rd_data, 32'd0);

    // DIV by zero runs the full window; MTHI and MULT issued meanwhile are ignored.
    op_valid = 1'b1;
    md_op    = 4'd3;
    rs_val   = 32'd5;
    rt_val   = 32'd0;
    tick();
    idle_in();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("div0 busy[%0d]", i), {31'd0, busy}, 32'd1);
      if (i == 2) begin
        op_valid = 1'b1;
        md_op    = 4'd5;
        rs_val   = 32'hDEAD;
      end else if (i == 3) begin
        op_valid = 1'b1;
        md_op    = 4'd1;
        rs_val   = 32'd9;
        rt_val   = 32'd9;
      end else begin
        idle_in();
      end
      tick();
    end
    idle_in();
    check("div0 busy_after", {31'd0, busy}, 32'd0);
    check("div0 hi", hi, 32'd0);
    check("div0 lo", lo, 32'h1234);
    rd_sel = 1'b0;

    // Reset in the third busy cycle of a DIV abandons it for good.
    op_valid = 1'b1;
    md_op    = 4'd4;
    rs_val   = 32'd7;
    rt_val   = 32'd2;
    tick();
    idle_in();
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rstmid busy", {31'd0, busy}, 32'd0);
    check("rstmid hi", hi, 32'd0);
    check("rstmid lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("rstmid late hi", hi, 32'd0);
    check("rstmid late lo", lo, 32'd0);

`ifdef MD_MADD_EN
    mt(4'd6, 32'hFFFFFFFF);
    run_op("maddu", 4'd8, 32'd1, 32'd1, 5, 1'b0, 32'd1, 32'd0);
    mt(4'd5, 32'd0);
    run_op("msub", 4'd9, 32'd2, 32'd3, 5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA);
`else
    mt(4'd6, 32'h55);
    run_op("op7none", 4'd7, 32'd2, 32'd3, 0, 1'b1, 32'd0, 32'h55);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/stage_muldiv.md
Name: stage_muldiv

Overview:
- Multi-cycle multiply/divide unit and its sequencer, beside the execute stage ALU.
- Owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU over a fixed cycle count.
- Executes MTHI/MTLO and serves MFHI/MFLO reads.
- Raises a stall request to the hazard unit while a later instruction in decode needs the unit and it is occupied.

Parameters:
MUL_CYCLES  5   cycles busy is held after an accepted multiply (>=1)
DIV_CYCLES  10  cycles busy is held after an accepted divide (>=1)

Ports:
clk        input   1   clock; all state updates on rising edge
reset_n    input   1   synchronous, active-low reset, sampled on rising edge of clk
op_valid   input   1   execute-stage instruction carries an md operation this cycle
md_op      input   4   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7-10 see Optional Feature, others NONE
rs_val     input   32  forwarded rs operand (dividend / multiplicand / MT source)
rt_val     input   32  forwarded rt operand (divisor / multiplier)
rd_sel     input   1   0 selects LO, 1 selects HI for rd_data
d_md_use   input   1   decode-stage instruction is any md op or MFHI/MFLO
busy       output  1   multi-cycle operation in progress
stall_req  output  1   stall decode/fetch this cycle
hi         output  32  HI register
lo         output  32  LO register
rd_data    output  32  rd_sel ? hi : lo, combinational (MFHI/MFLO result)

Behaviour:
- Reset (reset_n=0 at edge): hi=0, lo=0, counter=0, busy=0, pending result cleared. Reset mid-operation abandons it; HI/LO stay 0.
- accept = op_valid & ~busy & md_op in {1..4} (plus 7..10 with the feature).
- Counter:
  - On the accept edge, counter <= MUL_CYCLES (ops 1,2,7-10) or DIV_CYCLES (3,4).
  - Operands are latched into internal registers at that edge.
  - busy = (counter != 0), registered.
  - Each edge with counter != 0 decrements it.
  - On the edge where the counter goes 1->0, the latched result is written to HI/LO.
- Timing: accept at edge T gives busy high for exactly N cycles. New HI/LO is visible in the first cycle busy is low.
- Result computation: may be done at accept and held, or iteratively. Only the externally visible timing above is required.
- MULT: {hi,lo} = signed 64-bit product. MULTU: unsigned 64-bit product.
- DIV:
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (rt_val=0): busy runs the full DIV_CYCLES; HI/LO unchanged at completion.
- MTHI/MTLO:
  - op_valid & ~busy: hi (or lo) <= rs_val at the next edge. Single cycle; busy not asserted.
  - While busy: ignored.
- op_valid with an md op while busy is ignored. The hazard unit guarantees this cannot occur; the bench checks that state is unaffected.
- stall_req = d_md_use & (busy | accept). Combinational from the registered busy and the current inputs.
- rd_data during busy returns the old HI/LO. Consumers are stalled by stall_req, so stale reads never commit.
- No overflow or exception output; all md arithmetic is modulo-width.

Optional Feature:
- Macro MD_MADD_EN.
- Defined: opcodes 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU are accepted with MUL_CYCLES latency.
  - {hi,lo} <= {hi,lo} +/- product, where product is signed (7,9) or unsigned (8,10), 64-bit wrap.
  - The {hi,lo} used is the value at accept.
- Undefined: opcodes 7-10 behave as NONE (no accept, no state change, no stall contribution from accept).

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3 accepted at T -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Stall: start MULT with d_md_use=1 in the same cycle -> stall_req=1 that cycle and all 5 busy cycles, 0 the cycle after; with d_md_use=0 -> stall_req stays 0.
- MTLO rs=0x1234 while idle -> lo=0x1234 next cycle, busy never set, rd_sel=0 gives rd_data=0x1234. Then DIV rt=0 -> busy 10 cycles, hi/lo unchanged. Then MTHI issued while busy -> ignored.
- Reset: reset_n=0 at cycle 3 of a DIV -> busy=0, hi=lo=0 next cycle, no late write-back after 10 cycles.
- With MD_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1*1 -> hi=1, lo=0. MSUB 2*3 from {0,0} -> hi=lo=0xFFFFFFFF/0xFFFFFFFA. Without the macro: op 7 leaves state and busy untouched.
